mem_arbiter: RTL and testbench

//   Two-requester arbiter/sequencer in front of the single-port data memory
//   (address, writeData, memRead, memWrite, readData). Port 0 = instruction

---
 rtl/mem_arbiter_if.sv | 35 +++
 rtl/mem_arbiter.sv | 108 ++++++++++
 tb/tb_mem_arbiter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports and the single-port memory bus seen by mem_arbiter.
// slave is the arbiter side; master is the requester/memory side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic              we0;
  logic [DATA_W-1:0] wdata0;
  logic              ack0;
  logic [DATA_W-1:0] rdata0;
  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic              we1;
  logic [DATA_W-1:0] wdata1;
  logic              ack1;
  logic [DATA_W-1:0] rdata1;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] writeData;
  logic              memRead;
  logic              memWrite;
  logic [DATA_W-1:0] readData;
  logic              busy;

  modport slave (
    input  req0, addr0, we0, wdata0, req1, addr1, we1, wdata1, readData,
    output ack0, rdata0, ack1, rdata1, address, writeData, memRead, memWrite, busy
  );

  modport master (
    output req0, addr0, we0, wdata0, req1, addr1, we1, wdata1, readData,
    input  ack0, rdata0, ack1, rdata1, address, writeData, memRead, memWrite, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin two-port sequencer in front of a single-port data memory.
// Each grant holds the memory inputs for LAT cycles, then pulses ack with read data.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LAT    = 1
) (
  input  logic          CLK,
  input  logic          RESET,
  mem_arbiter_if.slave  bus
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state, state_n;
  logic [3:0]        cnt;
  logic              last_grant;
  logic              g;
  logic              we_lat;
  logic [ADDR_W-1:0] addr_lat;
  logic [DATA_W-1:0] wdata_lat;
  logic              ack0, ack1;
  logic [DATA_W-1:0] rdata0, rdata1;

  logic              elig0, elig1;
  logic              grant_v, grant_id, done;

  // A port whose ack is on the bus this cycle has just been served and must
  // drop its request before it can be granted again.
  assign elig0 = bus.req0 & ~ack0;
  assign elig1 = bus.req1 & ~ack1;

  always_comb begin
    state_n  = state;
    grant_v  = 1'b0;
    grant_id = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (elig0 && elig1) begin
          grant_v  = 1'b1;
          grant_id = ~last_grant;
        end else if (elig0) begin
          grant_v  = 1'b1;
        end else if (elig1) begin
          grant_v  = 1'b1;
          grant_id = 1'b1;
        end
        if (grant_v) state_n = ACCESS;
      end
      ACCESS: begin
        if (cnt == 4'd0) begin
          done    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      last_grant <= 1'b1;
      g          <= 1'b0;
      we_lat     <= 1'b0;
      addr_lat   <= '0;
      wdata_lat  <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      state <= state_n;
      ack0  <= done & ~g;
      ack1  <= done & g;
      if (grant_v) begin
        g         <= grant_id;
        addr_lat  <= grant_id ? bus.addr1  : bus.addr0;
        wdata_lat <= grant_id ? bus.wdata1 : bus.wdata0;
        we_lat    <= grant_id ? bus.we1    : bus.we0;
        cnt       <= 4'(LAT - 1);
      end else if (state == ACCESS && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (done) begin
        last_grant <= g;
        if (!we_lat) begin
          if (g) rdata1 <= bus.readData;
          else   rdata0 <= bus.readData;
        end
      end
    end
  end

  // Write strobe only on the final ACCESS cycle so each write commits exactly once.
  assign bus.address   = (state == ACCESS) ? addr_lat  : '0;
  assign bus.writeData = (state == ACCESS) ? wdata_lat : '0;
  assign bus.memRead   = (state == ACCESS) & ~we_lat;
  assign bus.memWrite  = (state == ACCESS) & we_lat & (cnt == 4'd0);
  assign bus.busy      = (state == ACCESS);
  assign bus.ack0      = ack0;
  assign bus.ack1      = ack1;
  assign bus.rdata0    = rdata0;
  assign bus.rdata1    = rdata1;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one LAT=1 and one LAT=3 instance, each with a
// 16-word memory model preloaded with mem[i]=i.
module tb_mem_arbiter;

  logic CLK = 1'b0;
  logic RESET;
  logic mem_init;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc;

  always #5 CLK = ~CLK;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) if1 ();
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) if3 ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(1)) u_lat1 (.CLK(CLK), .RESET(RESET), .bus(if1.slave));
  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(3)) u_lat3 (.CLK(CLK), .RESET(RESET), .bus(if3.slave));

  logic [31:0] mem1 [0:15];
  logic [31:0] mem3 [0:15];

  assign if1.readData = mem1[if1.address[3:0]];
  assign if3.readData = mem3[if3.address[3:0]];

  always @(posedge CLK) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) begin
        mem1[i] <= 32'(i);
        mem3[i] <= 32'(i);
      end
    end else begin
      if (if1.memWrite) mem1[if1.address[3:0]] <= if1.writeData;
      if (if3.memWrite) mem3[if3.address[3:0]] <= if3.writeData;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    if1.req0 = 0; if1.addr0 = 0; if1.we0 = 0; if1.wdata0 = 0;
    if1.req1 = 0; if1.addr1 = 0; if1.we1 = 0; if1.wdata1 = 0;
    if3.req0 = 0; if3.addr0 = 0; if3.we0 = 0; if3.wdata0 = 0;
    if3.req1 = 0; if3.addr1 = 0; if3.we1 = 0; if3.wdata1 = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RESET = 1'b1;
    mem_init = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
    mem_init = 1'b0;
    cyc = 0;
  endtask

  int exp_cyc  [10] = '{2, 5, 7, 9, 11, 13, 15, 17, 19, 21};
  int exp_port [10] = '{0, 0, 1, 0, 1, 0, 1, 0, 1, 0};
  int got_cyc  [10];
  int got_port [10];
  int nacks;
  int wr_cnt;
  int rd_cnt;

  initial begin
    cyc = 0;
    do_reset();

    // reset state
    check("rst_ack0",  32'(if1.ack0), 32'd0);
    check("rst_ack1",  32'(if1.ack1), 32'd0);
    check("rst_rdata0", if1.rdata0, 32'd0);
    check("rst_rdata1", if1.rdata1, 32'd0);
    check("rst_addr",  if1.address, 32'd0);
    check("rst_mrd",   32'(if1.memRead), 32'd0);
    check("rst_busy",  32'(if1.busy), 32'd0);
    check("rst_busy3", 32'(if3.busy), 32'd0);

    // 1: single read, LAT=1
    if1.req0 = 1; if1.addr0 = 5; if1.we0 = 0;
    tick();
    check("t1_mrd_c1",  32'(if1.memRead), 32'd1);
    check("t1_addr_c1", if1.address, 32'd5);
    check("t1_ack0_c1", 32'(if1.ack0), 32'd0);
    tick();
    check("t1_ack0_c2", 32'(if1.ack0), 32'd1);
    check("t1_rdata0",  if1.rdata0, 32'd5);
    check("t1_ack1_c2", 32'(if1.ack1), 32'd0);
    check("t1_mrd_c2",  32'(if1.memRead), 32'd0);
    if1.req0 = 0;
    tick();
    check("t1_ack0_c3", 32'(if1.ack0), 32'd0);
    check("t1_ack1_c3", 32'(if1.ack1), 32'd0);

    // 2: round-robin
    do_reset();
    if1.req0 = 1; if1.addr0 = 4;
    if1.req1 = 1; if1.addr1 = 9;
    tick();
    check("t2_addr_c1", if1.address, 32'd4);
    tick();
    check("t2_ack0_c2", 32'(if1.ack0), 32'd1);
    check("t2_ack1_c2", 32'(if1.ack1), 32'd0);
    check("t2_rdata0",  if1.rdata0, 32'd4);
    if1.req0 = 0;
    tick();
    check("t2_addr_c3", if1.address, 32'd9);
    tick();
    check("t2_ack1_c4", 32'(if1.ack1), 32'd1);
    check("t2_rdata1",  if1.rdata1, 32'd9);
    if1.req1 = 0;
    if1.req0 = 1; if1.addr0 = 6;
    tick();
    tick();
    check("t2_ack0_c6", 32'(if1.ack0), 32'd1);
    check("t2_rdata0b", if1.rdata0, 32'd6);
    if1.req0 = 1; if1.addr0 = 12;
    if1.req1 = 1; if1.addr1 = 13;
    tick();
    check("t2_addr_c7", if1.address, 32'd13);
    tick();
    check("t2_ack1_c8", 32'(if1.ack1), 32'd1);
    check("t2_ack0_c8", 32'(if1.ack0), 32'd0);
    check("t2_rdata1b", if1.rdata1, 32'd13);
    if1.req1 = 0;
    tick();
    tick();
    check("t2_ack0_c10", 32'(if1.ack0), 32'd1);
    check("t2_rdata0c",  if1.rdata0, 32'd12);
    if1.req0 = 0;

    // 3: write then read back
    do_reset();
    if1.req1 = 1; if1.addr1 = 3; if1.we1 = 1; if1.wdata1 = 32'hDEAD;
    wr_cnt = 0;
    tick();
    if (if1.memWrite) wr_cnt++;
    check("t3_wdata", if1.writeData, 32'hDEAD);
    tick();
    if (if1.memWrite) wr_cnt++;
    check("t3_ack1", 32'(if1.ack1), 32'd1);
    if1.req1 = 0; if1.we1 = 0;
    if1.req0 = 1; if1.addr0 = 3; if1.we0 = 0;
    tick();
    if (if1.memWrite) wr_cnt++;
    tick();
    if (if1.memWrite) wr_cnt++;
    check("t3_wr_cnt", 32'(wr_cnt), 32'd1);
    check("t3_ack0",   32'(if1.ack0), 32'd1);
    check("t3_rdata0", if1.rdata0, 32'hDEAD);
    check("t3_rdata1", if1.rdata1, 32'd0);
    if1.req0 = 0;

    // 4: LAT=3 read
    do_reset();
    if3.req0 = 1; if3.addr0 = 7;
    rd_cnt = 0;
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (if3.memRead) rd_cnt++;
      check("t4_addr", if3.address, 32'd7);
      check("t4_ack0_early", 32'(if3.ack0), 32'd0);
    end
    tick();
    check("t4_rd_cnt", 32'(rd_cnt), 32'd3);
    check("t4_ack0",   32'(if3.ack0), 32'd1);
    check("t4_rdata0", if3.rdata0, 32'd7);
    check("t4_mrd_c4", 32'(if3.memRead), 32'd0);
    if3.req0 = 0;

    // 5: reset during a LAT=3 write
    do_reset();
    if3.req1 = 1; if3.addr1 = 2; if3.we1 = 1; if3.wdata1 = 32'h55;
    wr_cnt = 0;
    tick();
    check("t5_busy_c1", 32'(if3.busy), 32'd1);
    if (if3.memWrite) wr_cnt++;
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    if3.req1 = 0; if3.we1 = 0;
    check("t5_busy_c2", 32'(if3.busy), 32'd0);
    for (int c = 0; c < 6; c++) begin
      if (if3.memWrite) wr_cnt++;
      check("t5_no_ack1", 32'(if3.ack1), 32'd0);
      tick();
    end
    check("t5_wr_cnt", 32'(wr_cnt), 32'd0);
    if3.req0 = 1; if3.addr0 = 2;
    for (int c = 0; c < 4; c++) tick();
    check("t5_ack0",   32'(if3.ack0), 32'd1);
    check("t5_rdback", if3.rdata0, 32'd2);
    if3.req0 = 0;

    // 6: port 0 streaming, port 1 joins mid-stream
    do_reset();
    if1.req0 = 1; if1.addr0 = 1;
    nacks = 0;
    while (nacks < 10 && cyc < 40) begin
      tick();
      if (if1.ack0 && if1.ack1) check("t6_dual_ack", 32'd1, 32'd0);
      if ((if1.ack0 || if1.ack1) && nacks < 10) begin
        got_cyc[nacks]  = cyc;
        got_port[nacks] = if1.ack1 ? 1 : 0;
        nacks++;
      end
      if (cyc == 4) begin
        if1.req1 = 1; if1.addr1 = 11;
      end
    end
    if1.req0 = 0; if1.req1 = 0;
    check("t6_nacks", 32'(nacks), 32'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < nacks) begin
        check($sformatf("t6_cyc%0d", i),  got_cyc[i],  exp_cyc[i]);
        check($sformatf("t6_port%0d", i), got_port[i], exp_port[i]);
      end
    end
    check("t6_rdata0", if1.rdata0, 32'd1);
    check("t6_rdata1", if1.rdata1, 32'd11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
